// File: rtl/delay_chain_pkg.sv
// delay_chain_pkg: shared helpers for the delay line (pointer width derivation)
package delay_chain_pkg;
  // Pointer bits for a circular buffer of len-1 entries, never narrower than 1 bit.
  function automatic int ptr_w(input int len);
    return (len > 2) ? $clog2(len - 1) : 1;
  endfunction
endpackage

// File: rtl/delay_chain_mem_core.sv
// delay_chain_mem_core: circular-buffer delay of LEN enabled cycles (LEN-1 entry array + output register)
//   clk   : rising-edge clock
//   rst   : async active-high reset, clears pointer and output register (array is not reset)
//   i_en  : clock enable, all state holds when low
//   i_d   : data in
//   o_q   : data out, i_d delayed by LEN enabled edges
module delay_chain_mem_core
  import delay_chain_pkg::*;
#(
  parameter int DW  = 8,
  parameter int LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);
  localparam int DEPTH = LEN - 1;
  localparam int PW    = ptr_w(LEN);
  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [DW-1:0] r_q;
  logic [DW-1:0] w_rd;
  assign w_rd = r_mem[r_ptr];
  assign o_q  = r_q;
  // Array has no reset so it can map onto RAM; read-before-write on the same slot.
  always_ff @(posedge clk)
    if (i_en) r_mem[r_ptr] <= i_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ptr <= '0;
      r_q   <= '0;
    end else if (i_en) begin
      r_q   <= w_rd;
      r_ptr <= (r_ptr == PW'(LEN - 2)) ? '0 : r_ptr + PW'(1);
    end
endmodule

// File: rtl/delay_chain.sv
// delay_chain: fixed-latency delay line, register chain or circular-buffer memory style
//   clk : rising-edge clock
//   rst : async active-high reset
//   en  : clock enable; delay is counted in enabled edges only
//   in  : data in (DW bits)
//   out : in delayed by LEN enabled edges (LEN=0 is a wire)
module delay_chain
  import delay_chain_pkg::*;
#(
  parameter int DW      = 8,
  parameter int LEN     = 4,
  parameter int USE_MEM = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out
);
  if (LEN == 0) begin : g_wire
    assign out = in;
  end else if (USE_MEM != 0 && LEN >= 2) begin : g_mem
    delay_chain_mem_core #(.DW(DW), .LEN(LEN)) u_core (
      .clk  (clk),
      .rst  (rst),
      .i_en (en),
      .i_d  (in),
      .o_q  (out)
    );
  end else begin : g_reg
    logic [DW-1:0] r_stage [LEN];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int k = 0; k < LEN; k++) r_stage[k] <= '0;
      end else if (en) begin
        r_stage[0] <= in;
        for (int k = 1; k < LEN; k++) r_stage[k] <= r_stage[k-1];
      end
    assign out = r_stage[LEN-1];
  end
endmodule

// File: tb/tb_delay_chain.sv
// tb_delay_chain: randomized and directed checks of delay_chain in both styles against a history-queue model
module tb_delay_chain;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] in_val;
  logic [7:0]  o_r3, o_r4, o_m4, o_m1;
  logic [15:0] o_z0, o_m8, o_m5;
  logic [11:0] o_r16, o_m16;
  int checks = 0;
  int failures = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  delay_chain #(.DW(8),  .LEN(3),  .USE_MEM(0)) u_r3  (.clk(clk), .rst(rst), .en(en), .in(in_val[7:0]),  .out(o_r3));
  delay_chain #(.DW(16), .LEN(0),  .USE_MEM(0)) u_z0  (.clk(clk), .rst(rst), .en(en), .in(in_val),       .out(o_z0));
  delay_chain #(.DW(16), .LEN(8),  .USE_MEM(1)) u_m8  (.clk(clk), .rst(rst), .en(en), .in(in_val),       .out(o_m8));
  delay_chain #(.DW(16), .LEN(5),  .USE_MEM(1)) u_m5  (.clk(clk), .rst(rst), .en(en), .in(in_val),       .out(o_m5));
  delay_chain #(.DW(8),  .LEN(4),  .USE_MEM(0)) u_r4  (.clk(clk), .rst(rst), .en(en), .in(in_val[7:0]),  .out(o_r4));
  delay_chain #(.DW(8),  .LEN(4),  .USE_MEM(1)) u_m4  (.clk(clk), .rst(rst), .en(en), .in(in_val[7:0]),  .out(o_m4));
  delay_chain #(.DW(8),  .LEN(1),  .USE_MEM(1)) u_m1  (.clk(clk), .rst(rst), .en(en), .in(in_val[7:0]),  .out(o_m1));
  delay_chain #(.DW(12), .LEN(16), .USE_MEM(0)) u_r16 (.clk(clk), .rst(rst), .en(en), .in(in_val[11:0]), .out(o_r16));
  delay_chain #(.DW(12), .LEN(16), .USE_MEM(1)) u_m16 (.clk(clk), .rst(rst), .en(en), .in(in_val[11:0]), .out(o_m16));

  // Value that entered L enabled edges ago since reset, or 0 if not that many yet.
  function automatic logic [15:0] exp_of(input int l, input int w);
    logic [15:0] m;
    m = 16'((32'h1 << w) - 1);
    return (q.size() < l) ? 16'h0 : (q[q.size() - l] & m);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory outputs are only defined before the first edge after reset or once the line has filled.
  task automatic check_all();
    int n;
    n = q.size();
    chk("z0",  o_z0, in_val);
    chk("r3",  {8'h0, o_r3},  exp_of(3, 8));
    chk("r4",  {8'h0, o_r4},  exp_of(4, 8));
    chk("m1",  {8'h0, o_m1},  exp_of(1, 8));
    chk("r16", {4'h0, o_r16}, exp_of(16, 12));
    if (n == 0 || n >= 8)  chk("m8",  o_m8, exp_of(8, 16));
    if (n == 0 || n >= 5)  chk("m5",  o_m5, exp_of(5, 16));
    if (n == 0 || n >= 4)  chk("m4",  {8'h0, o_m4},  exp_of(4, 8));
    if (n == 0 || n >= 16) chk("m16", {4'h0, o_m16}, exp_of(16, 12));
    if (n >= 16) chk("eq16", {4'h0, o_m16}, {4'h0, o_r16});
  endtask

  task automatic step(input logic e, input logic [15:0] d);
    en = e;
    in_val = d;
    @(posedge clk);
    if (!rst && e) q.push_back(d);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    en = 1'b0;
    in_val = '0;
    repeat (2) @(negedge clk);
    check_all();
    in_val = 16'h1234;
    #1 chk("z0_rst_a", o_z0, 16'h1234);
    in_val = 16'hBEEF;
    #1 chk("z0_rst_b", o_z0, 16'hBEEF);
    @(negedge clk);
    rst = 1'b0;
    check_all();
    for (int i = 0; i < 40; i++) step(1'b1, 16'(i + 1));
    for (int i = 0; i < 20; i++) step(1'b1, 16'(100 + i));
    for (int i = 0; i < 28; i++) step(pat[i % 7], 16'($urandom));
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16'hAA + 16'h11 * i));
    #2 rst = 1'b1;
    q.delete();
    #1 check_all();
    step(1'b1, 16'h5A5A);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) step(($urandom_range(0, 3) != 0), 16'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/delay_chain.md
Name: delay_chain

Overview:
- Parameterised fixed-latency delay line: out equals in delayed by LEN clock-enabled cycles.
- Two implementation styles, selected by parameter:
  - register shift chain (resettable), used for control/counter alignment;
  - circular-buffer memory (RAM-inferable), used for long data delays in pipelined FFT feedback paths.
- Delay is counted in enabled cycles only.

Parameters:
- DW, 8, data width in bits; must be at least 1.
- LEN, 4, delay in enabled clock cycles; must be at least 0. LEN=0 is a combinational pass-through.
- USE_MEM, 0:
  - 0 selects the register-chain style.
  - 1 selects the memory style, which requires LEN of 2 or more; LEN of 1 or less falls back to the register style.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  clock enable; when low, all state holds.
- in  input  DW  data input.
- out  output  DW  data output; in delayed by LEN enabled cycles.

Behaviour:
- LEN=0: out = in combinationally. No state; rst and en have no effect.
- Register style (USE_MEM=0, or LEN=1):
  - LEN stages of DW bits each. On every enabled rising edge, stage0 <= in and stage k <= stage k-1. out = last stage.
  - rst clears all stages to 0 immediately. out reads 0 while rst is high, and stays 0 for the first LEN enabled edges after release.
- Memory style (USE_MEM=1, LEN of 2 or more):
  - LEN-1 entry array, a write/read pointer of ceil(log2(LEN-1)) bits (minimum 1 bit), and a DW-bit output register.
  - On an enabled edge:
    - read data = mem[ptr], read before the write in the same cycle;
    - out_reg <= read data;
    - mem[ptr] <= in;
    - ptr <= (ptr == LEN-2) ? 0 : ptr+1.
  - Resulting latency is exactly LEN enabled edges; the array contributes LEN-1 and the output register 1.
  - Pointer wrap is at LEN-2 exactly, so non-power-of-two LEN works.
  - rst asynchronously clears ptr and out_reg to 0. Array contents are NOT reset.
  - After reset, out is 0 for one edge, then undefined (X in simulation) until LEN enabled edges after release. Consumers must not rely on those values.
- en low: no pointer advance, no write, no shift. out holds its value, and the latency measured in enabled edges is preserved.
- rst asserted mid-stream: register style discards all in-flight data (all stages become 0). Memory style discards the output register and restarts the pointer; stale array data may reappear after reset.
- rst has priority over en.
- Both styles must be bit-identical after the first LEN enabled edges following reset. No arithmetic is performed; data is opaque.

Decomposition:
- No package types are needed.
- Parameters are plain integers. Width of the pointer is derived with $clog2.
- Natural sub-module: delay_chain_mem_core, the circular-buffer array plus pointer, instantiated by generate when USE_MEM=1 and LEN is 2 or more.
- The register chain and the LEN=0 wire are generate branches in the top module.
- Wide complex data is delayed by instantiating one delay_chain per component (re/im).

Test Plan:
- Register style, DW=8, LEN=3, en=1, in=1,2,3,… per cycle from reset release: out reads 0,0,0 on the first three edges, then 1,2,3,…
- LEN=0, DW=16: drive in=0x1234 then 0xBEEF with no clock edge: out tracks in combinationally, and is unaffected by rst=1.
- Memory style, DW=16, LEN=8:
  - ramp input from 100: out equals in(n-8) from the 9th edge onward;
  - run 40 cycles to cover pointer wrap at 6→0: no glitch or skip;
  - repeat with LEN=5 to confirm non-power-of-two wrap.
- Enable gating, both styles with LEN=4: toggle en in the pattern 1,0,1,1,0,0,1… with distinct inputs: out changes only on enabled edges, and each value appears exactly 4 enabled edges after capture.
- Async reset mid-stream, register style LEN=4, streaming 0xAA, 0xBB…: assert rst between clock edges. out goes to 0 without waiting for a clock edge, and 4 post-release enabled edges later the first new input emerges.
- Equivalence: USE_MEM=0 and USE_MEM=1 with LEN=16 and DW=12, fed the same random stream: outputs are identical from edge 17 after reset onward.
